rgmii_delay_tuner: RTL and testbench

Runtime controller for the RGMII receive-path input delays (IDELAYE2 in VAR_LOAD mode). It replaces fixed compile-time tap values with register-programmable taps. It also has an automatic eye scan: the scan sweeps the data tap, scores each tap using MAC good/bad frame pulses, and loads the centre of the widest passing window. It sits beside the RGMII MAC wrapper in the 125 MHz MAC clock domain, which also clocks the IDELAYE2 C pins.

---
 rtl/rgmii_delay_tuner_if.sv | 35 +++
 rtl/rgmii_delay_tuner.sv | 176 +++++++++++++++++
 tb/tb_rgmii_delay_tuner.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_delay_tuner_if.sv
// Control/status bundle between the RGMII delay tuner and its surroundings:
// IDELAYCTRL ready, register-side config, MAC frame scoring pulses and the
// IDELAYE2 VAR_LOAD controls.
interface rgmii_delay_tuner_if #(
  parameter int TAP_WIDTH = 5
);
  logic                 idelay_rdy;
  logic [TAP_WIDTH-1:0] cfg_clk_tap;
  logic [TAP_WIDTH-1:0] cfg_data_tap;
  logic                 cfg_apply;
  logic                 cfg_scan;
  logic                 frame_good;
  logic                 frame_bad;
  logic [TAP_WIDTH-1:0] clk_cntvalue;
  logic [TAP_WIDTH-1:0] data_cntvalue;
  logic                 idelay_ld;
  logic                 busy;
  logic                 scan_done;
  logic                 scan_fail;
  logic [TAP_WIDTH:0]   window_len;

  modport master (
    output idelay_rdy, cfg_clk_tap, cfg_data_tap, cfg_apply, cfg_scan,
           frame_good, frame_bad,
    input  clk_cntvalue, data_cntvalue, idelay_ld, busy, scan_done,
           scan_fail, window_len
  );

  modport slave (
    input  idelay_rdy, cfg_clk_tap, cfg_data_tap, cfg_apply, cfg_scan,
           frame_good, frame_bad,
    output clk_cntvalue, data_cntvalue, idelay_ld, busy, scan_done,
           scan_fail, window_len
  );
endinterface

// File: rtl/rgmii_delay_tuner.sv
// Runtime IDELAYE2 tap controller for the RGMII receive path. Holds the
// clock-lane and data-lane taps, loads them on request, and can sweep the
// data tap scoring each position with MAC good/bad frame pulses, then park
// on the centre of the widest passing window.
module rgmii_delay_tuner #(
  parameter int TAP_WIDTH        = 5,
  parameter int DEFAULT_CLK_TAP  = 0,
  parameter int DEFAULT_DATA_TAP = 25,
  parameter int SETTLE_CYCLES    = 64,
  parameter int DWELL_FRAMES     = 16,
  parameter int TIMEOUT_CYCLES   = 2**20
) (
  input  logic                  clock,
  input  logic                  reset,
  rgmii_delay_tuner_if.slave    bus
);

  localparam int FW   = $clog2(DWELL_FRAMES + 1);
  localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;
  localparam logic [FW-1:0]        DWELL_N     = FW'(DWELL_FRAMES);
  localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]        TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    WAIT_RDY, LOAD, IDLE, S_LOAD, S_SETTLE, S_DWELL, S_NEXT, S_FINISH, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [TAP_WIDTH-1:0] clk_q, data_q, save_q;
  logic [CW-1:0]        cyc_q;
  logic [FW-1:0]        frm_q;
  logic                 bad_q, pass_q, fail_q;
  logic [TAP_WIDTH-1:0] run_start_q, best_start_q;
  logic [TAP_WIDTH:0]   run_len_q, best_len_q, win_q;

  logic                 ld, busy, done, abort;
  logic [FW:0]          frm_sum;
  logic [FW-1:0]        frm_nxt;
  logic                 bad_nxt, frm_full, tmo, dwell_end;
  logic [TAP_WIDTH:0]   fin_len, fin_half;
  logic [TAP_WIDTH-1:0] fin_start;

  // Dwell scoring: both pulses in one cycle count as two frames, saturating.
  always_comb begin
    frm_sum   = {1'b0, frm_q} + (FW+1)'(bus.frame_good) + (FW+1)'(bus.frame_bad);
    frm_nxt   = (frm_sum >= {1'b0, DWELL_N}) ? DWELL_N : frm_sum[FW-1:0];
    bad_nxt   = bad_q | bus.frame_bad;
    frm_full  = (frm_nxt == DWELL_N);
    tmo       = (cyc_q == TMO_LAST);
    dwell_end = frm_full | tmo;
  end

  // Close the run that touches the top tap and pick the centre of the best.
  always_comb begin
    fin_len   = (run_len_q > best_len_q) ? run_len_q   : best_len_q;
    fin_start = (run_len_q > best_len_q) ? run_start_q : best_start_q;
    fin_half  = (fin_len - 1'b1) >> 1;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= WAIT_RDY;
    else       state_q <= state_d;
  end

  // Next state and decoded strobes; losing IDELAYCTRL ready overrides all.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      WAIT_RDY: if (bus.idelay_rdy) state_d = LOAD;
      LOAD:     begin ld = 1'b1; state_d = IDLE; end
      IDLE: begin
        if (bus.cfg_apply)     state_d = LOAD;
        else if (bus.cfg_scan) state_d = S_LOAD;
      end
      S_LOAD:   begin busy = 1'b1; ld = 1'b1; state_d = S_SETTLE; end
      S_SETTLE: begin busy = 1'b1; if (cyc_q == SETTLE_LAST) state_d = S_DWELL; end
      S_DWELL:  begin busy = 1'b1; if (dwell_end) state_d = S_NEXT; end
      S_NEXT:   begin busy = 1'b1; state_d = (data_q == TAP_MAX) ? S_FINISH : S_LOAD; end
      S_FINISH: begin busy = 1'b1; state_d = S_DONE; end
      S_DONE:   begin ld = 1'b1; done = 1'b1; state_d = IDLE; end
      default:  state_d = WAIT_RDY;
    endcase
    abort = !bus.idelay_rdy && (state_q != WAIT_RDY);
    if (abort) state_d = WAIT_RDY;
  end

  // Tap registers, scoring counters and run tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_q        <= TAP_WIDTH'(DEFAULT_CLK_TAP);
      data_q       <= TAP_WIDTH'(DEFAULT_DATA_TAP);
      save_q       <= TAP_WIDTH'(DEFAULT_DATA_TAP);
      cyc_q        <= '0;
      frm_q        <= '0;
      bad_q        <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      win_q        <= '0;
    end else if (abort) begin
      // Scan abandoned: put back the tap that was in force before it.
      if (busy) data_q <= save_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_apply) begin
            clk_q  <= bus.cfg_clk_tap;
            data_q <= bus.cfg_data_tap;
          end else if (bus.cfg_scan) begin
            save_q       <= data_q;
            data_q       <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
          end
        end
        S_LOAD: begin
          cyc_q <= '0;
          frm_q <= '0;
          bad_q <= 1'b0;
        end
        S_SETTLE: cyc_q <= (cyc_q == SETTLE_LAST) ? '0 : cyc_q + CW'(1);
        S_DWELL: begin
          cyc_q <= cyc_q + CW'(1);
          frm_q <= frm_nxt;
          bad_q <= bad_nxt;
          if (dwell_end) pass_q <= frm_full & ~bad_nxt;
        end
        S_NEXT: begin
          if (pass_q) begin
            if (run_len_q == '0) run_start_q <= data_q;
            run_len_q <= run_len_q + 1'b1;
          end else begin
            if (run_len_q > best_len_q) begin
              best_len_q   <= run_len_q;
              best_start_q <= run_start_q;
            end
            run_len_q <= '0;
          end
          if (data_q != TAP_MAX) data_q <= data_q + 1'b1;
        end
        S_FINISH: begin
          win_q <= fin_len;
          if (fin_len != '0) begin
            data_q <= fin_start + fin_half[TAP_WIDTH-1:0];
            fail_q <= 1'b0;
          end else begin
            data_q <= save_q;
            fail_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.clk_cntvalue  = clk_q;
  assign bus.data_cntvalue = data_q;
  assign bus.idelay_ld     = ld;
  assign bus.busy          = busy;
  assign bus.scan_done     = done;
  assign bus.scan_fail     = fail_q;
  assign bus.window_len    = win_q;

endmodule

// File: tb/tb_rgmii_delay_tuner.sv
// Bench for rgmii_delay_tuner: table of scan scenarios (directed + random
// eye maps scored by a reference model), plus hand sequences for reset,
// manual apply, ready loss and reset during a scan.
module tb_rgmii_delay_tuner;
  localparam int TW = 5;

  logic clock = 1'b0;
  logic reset;
  always #4 clock = ~clock;

  rgmii_delay_tuner_if #(.TAP_WIDTH(TW)) bus();

  rgmii_delay_tuner #(
    .TAP_WIDTH(TW), .DEFAULT_CLK_TAP(0), .DEFAULT_DATA_TAP(25),
    .SETTLE_CYCLES(4), .DWELL_FRAMES(4), .TIMEOUT_CYCLES(40)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pmap;
    logic [31:0] bmap;
    int          mode;
    int          exp_len;
    int          exp_tap;
    logic        exp_fail;
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int failures = 0;
  int exp_clk, exp_data;

  logic [31:0] pass_map = '0, both_map = '0;
  int          mode = 0;
  int          cur_tap = 0;
  bit          mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Reference: longest run of passing taps, earliest wins ties, centre floor.
  function automatic void model(input logic [31:0] pm, output int len, output int tap);
    int best = 0, bs = 0, run = 0, rs = 0;
    for (int t = 0; t < 32; t++) begin
      if (pm[t]) begin
        if (run == 0) rs = t;
        run++;
        if (run > best) begin best = run; bs = rs; end
      end else run = 0;
    end
    len = best;
    tap = (best > 0) ? bs + (best - 1) / 2 : 0;
  endfunction

  // Frame source: follows the loaded tap and emits good/bad pulses for it,
  // never leaving more than two idle cycles so passing taps fill the dwell.
  initial begin
    int gap = 0;
    bit p;
    bus.frame_good = 1'b0;
    bus.frame_bad  = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (bus.idelay_ld) cur_tap = int'(bus.data_cntvalue);
      p = (gap >= 2) || ($urandom_range(0, 1) == 1);
      gap = p ? 0 : gap + 1;
      bus.frame_good = 1'b0;
      bus.frame_bad  = 1'b0;
      if (mode == 1) begin
        if (both_map[cur_tap]) begin
          bus.frame_good = p; bus.frame_bad = p;
        end else if (pass_map[cur_tap]) begin
          bus.frame_good = p;
        end else begin
          bus.frame_bad  = p;
          bus.frame_good = p & ($urandom_range(0, 1) == 1);
        end
      end
    end
  end

  // Output discipline: no back-to-back loads, taps only move with a load.
  logic            prev_ld = 1'b0;
  logic [TW-1:0]   prev_clk = '0, prev_data = '0;
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (bus.idelay_ld && prev_ld) begin
        failures++;
        $display("FAIL ld_consecutive: got 1 expected 0");
      end
      if (!bus.idelay_ld && (bus.clk_cntvalue != prev_clk || bus.data_cntvalue != prev_data)) begin
        failures++;
        $display("FAIL tap_stable: got %0d/%0d expected %0d/%0d",
                 bus.clk_cntvalue, bus.data_cntvalue, prev_clk, prev_data);
      end
    end
    prev_ld   = bus.idelay_ld;
    prev_clk  = bus.clk_cntvalue;
    prev_data = bus.data_cntvalue;
  end

  task automatic run_scan(input int idx, input bit hit_apply);
    int n = 0, lds = 0;
    bit got = 0;
    pass_map = vecs[idx].pmap;
    both_map = vecs[idx].bmap;
    mode     = vecs[idx].mode;
    bus.cfg_scan = 1'b1;
    tick();
    bus.cfg_scan = 1'b0;
    while (!got && n < 5000) begin
      if (bus.idelay_ld) lds++;
      if (bus.scan_done) got = 1;
      else begin
        bus.cfg_apply = hit_apply && (n == 10);
        bus.cfg_clk_tap  = 5'd7;
        bus.cfg_data_tap = 5'd7;
        tick();
        bus.cfg_apply = 1'b0;
        n++;
      end
    end
    chk($sformatf("scan%0d_done", idx), got, 1);
    chk($sformatf("scan%0d_ld_count", idx), lds, 33);
    chk($sformatf("scan%0d_ld_at_done", idx), bus.idelay_ld, 1);
    chk($sformatf("scan%0d_busy", idx), bus.busy, 0);
    chk($sformatf("scan%0d_fail", idx), bus.scan_fail, vecs[idx].exp_fail);
    chk($sformatf("scan%0d_window", idx), bus.window_len, vecs[idx].exp_len);
    if (!vecs[idx].exp_fail) exp_data = vecs[idx].exp_tap;
    chk($sformatf("scan%0d_data", idx), bus.data_cntvalue, exp_data);
    chk($sformatf("scan%0d_clk", idx), bus.clk_cntvalue, exp_clk);
    mode = 0;
    tick();
    chk($sformatf("scan%0d_idle", idx), bus.busy | bus.idelay_ld | bus.scan_done, 0);
  endtask

  initial begin
    int l, t, n;
    bit seen;
    logic [31:0] pm;

    vecs[0] = '{rng(10,19), 32'h0, 1, 10, 14, 1'b0};
    vecs[1] = '{rng(3,5) | rng(20,27), 32'h0, 1, 8, 23, 1'b0};
    vecs[2] = '{rng(2,5) | rng(20,23), 32'h0, 1, 4, 3, 1'b0};
    vecs[3] = '{32'h0, 32'h0, 0, 0, 0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0, 1, 32, 15, 1'b0};
    vecs[5] = '{rng(0,15) | rng(17,31), rng(16,16), 1, 16, 7, 1'b0};
    vecs[6] = '{rng(31,31), 32'h0, 1, 1, 31, 1'b0};
    vecs[7] = '{32'h0, 32'h0, 1, 0, 0, 1'b1};
    for (int i = 8; i < 12; i++) begin
      pm = $urandom() & $urandom();
      pm = pm | (32'h1 << $urandom_range(0, 31));
      model(pm, l, t);
      vecs[i] = '{pm, 32'h0, 1, l, t, 1'b0};
    end

    reset = 1'b1;
    bus.idelay_rdy = 1'b0;
    bus.cfg_clk_tap = '0; bus.cfg_data_tap = '0;
    bus.cfg_apply = 1'b0; bus.cfg_scan = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Reset state, then IDELAYCTRL ready gives one load of the defaults.
    chk("rst_ld", bus.idelay_ld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.scan_done, 0);
    chk("rst_fail", bus.scan_fail, 0);
    chk("rst_window", bus.window_len, 0);
    chk("rst_clk", bus.clk_cntvalue, 0);
    chk("rst_data", bus.data_cntvalue, 25);
    bus.idelay_rdy = 1'b1;
    tick();
    chk("rdy_ld", bus.idelay_ld, 1);
    chk("rdy_ld_taps", {bus.clk_cntvalue, bus.data_cntvalue}, {5'd0, 5'd25});
    seen = 0;
    repeat (4) begin tick(); seen |= bus.idelay_ld; end
    chk("rdy_single_ld", seen, 0);
    mon_en = 1;

    // Manual apply: latency one, new taps present with the load.
    bus.cfg_clk_tap = 5'd3; bus.cfg_data_tap = 5'd12; bus.cfg_apply = 1'b1;
    tick();
    bus.cfg_apply = 1'b0;
    chk("apply_ld", bus.idelay_ld, 1);
    chk("apply_taps", {bus.clk_cntvalue, bus.data_cntvalue}, {5'd3, 5'd12});
    tick();
    chk("apply_ld_off", bus.idelay_ld, 0);

    // Apply and scan together: apply wins, no scan starts.
    bus.cfg_clk_tap = 5'd4; bus.cfg_data_tap = 5'd13;
    bus.cfg_apply = 1'b1; bus.cfg_scan = 1'b1;
    tick();
    bus.cfg_apply = 1'b0; bus.cfg_scan = 1'b0;
    chk("both_ld_taps", {bus.idelay_ld, bus.clk_cntvalue, bus.data_cntvalue}, {1'b1, 5'd4, 5'd13});
    tick();
    chk("both_no_scan", bus.busy, 0);
    exp_clk = 4; exp_data = 13;

    for (int i = 0; i < 12; i++) run_scan(i, i == 0);

    // Ready loss mid-scan: abort, restore pre-scan taps, reload on return.
    pass_map = 32'hFFFF_FFFF; both_map = '0; mode = 1;
    bus.cfg_scan = 1'b1;
    tick();
    bus.cfg_scan = 1'b0;
    n = 0;
    while (!(bus.idelay_ld && bus.data_cntvalue == 5'd7) && n < 2000) begin tick(); n++; end
    chk("abort_reach_tap7", n < 2000, 1);
    repeat (3) tick();
    mon_en = 0;
    bus.idelay_rdy = 1'b0;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_taps", {bus.clk_cntvalue, bus.data_cntvalue}, {exp_clk[TW-1:0], exp_data[TW-1:0]});
    chk("abort_window_kept", bus.window_len, vecs[11].exp_len);
    seen = bus.scan_done | bus.idelay_ld;
    repeat (5) begin tick(); seen |= bus.scan_done | bus.idelay_ld; end
    chk("abort_quiet", seen, 0);
    mode = 0;
    bus.idelay_rdy = 1'b1;
    tick();
    chk("reload_ld", bus.idelay_ld, 1);
    chk("reload_taps", {bus.clk_cntvalue, bus.data_cntvalue}, {exp_clk[TW-1:0], exp_data[TW-1:0]});
    tick();
    chk("reload_idle", bus.idelay_ld | bus.busy | bus.scan_done, 0);
    mon_en = 1;

    // Reset during a scan returns every output to its reset value.
    mode = 1;
    bus.cfg_scan = 1'b1;
    tick();
    bus.cfg_scan = 1'b0;
    repeat (50) tick();
    chk("midscan_busy", bus.busy, 1);
    mon_en = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_outs", {bus.idelay_ld, bus.busy, bus.scan_done, bus.scan_fail}, 0);
    chk("midrst_window", bus.window_len, 0);
    chk("midrst_taps", {bus.clk_cntvalue, bus.data_cntvalue}, {5'd0, 5'd25});
    mode = 0;
    tick();
    chk("midrst_reload", {bus.idelay_ld, bus.data_cntvalue}, {1'b1, 5'd25});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
